// File: rtl/axi_pkg.sv
// Shared AXI encodings and FSM state type for the on-chip memory slave.
package axi_pkg;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   localparam logic [1:0] FIXED = 2'b00;
   localparam logic [1:0] INCR  = 2'b01;
   localparam logic [1:0] WRAP  = 2'b10;

   typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;

   // WRAP and the reserved code both walk forward like INCR; only FIXED holds the line.
   function automatic logic is_fixed(input logic [1:0] burst);
      return burst == FIXED;
   endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Byte-enabled line memory with one write port and one registered, enable-gated read port.
module axi_mem_array #(
   parameter int DATA_W     = 128,
   parameter int DEPTH_LOG2 = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   wstrb,
   input  logic                  re,
   input  logic [DEPTH_LOG2-1:0] raddr,
   output logic [DATA_W-1:0]     rdata
);

   logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      for (int b = 0; b < DATA_W/8; b++) begin
         if (we && wstrb[b]) begin
            mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   // Output register holds its value while re is low, which is what keeps RDATA stable under stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 slave backed by an on-chip array; serves one read or write burst at a time.
module axi_mem_slave
   import axi_pkg::*;
#(
   parameter int ADDR_W     = 27,
   parameter int DATA_W     = 128,
   parameter int DEPTH_LOG2 = 12
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
   input  logic [7:0]          S_AXI_AWLEN,
   input  logic [1:0]          S_AXI_AWBURST,
   input  logic                S_AXI_AWVALID,
   output logic                S_AXI_AWREADY,
   input  logic [DATA_W-1:0]   S_AXI_WDATA,
   input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
   input  logic                S_AXI_WLAST,
   input  logic                S_AXI_WVALID,
   output logic                S_AXI_WREADY,
   output logic [1:0]          S_AXI_BRESP,
   output logic                S_AXI_BVALID,
   input  logic                S_AXI_BREADY,
   input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
   input  logic [7:0]          S_AXI_ARLEN,
   input  logic [1:0]          S_AXI_ARBURST,
   input  logic                S_AXI_ARVALID,
   output logic                S_AXI_ARREADY,
   output logic [DATA_W-1:0]   S_AXI_RDATA,
   output logic [1:0]          S_AXI_RRESP,
   output logic                S_AXI_RLAST,
   output logic                S_AXI_RVALID,
   input  logic                S_AXI_RREADY
);

   state_t                state_reg;
   logic                  prio_wr_reg;
   logic [DEPTH_LOG2-1:0] line_reg;
   logic [7:0]            len_reg;
   logic [7:0]            cnt_reg;
   logic                  fixed_reg;
   logic                  err_reg;
   logic                  rd_more_reg;
   logic                  wready_reg;
   logic                  bvalid_reg;
   logic [1:0]            bresp_reg;
   logic                  rvalid_reg;
   logic                  rlast_reg;

   logic                  aw_sel;
   logic                  ar_sel;
   logic                  w_hs;
   logic                  last_beat;
   logic                  rd_en;
   logic [DEPTH_LOG2-1:0] line_next;
   logic                  unused_addr;

   // Readies are gated by rst so they read 0 during reset even if a master holds VALID.
   assign aw_sel = rst && (state_reg == IDLE) && S_AXI_AWVALID && (prio_wr_reg || !S_AXI_ARVALID);
   assign ar_sel = rst && (state_reg == IDLE) && S_AXI_ARVALID && (!prio_wr_reg || !S_AXI_AWVALID);

   assign w_hs      = wready_reg && S_AXI_WVALID;
   assign last_beat = (cnt_reg == len_reg);
   assign line_next = fixed_reg ? line_reg : line_reg + 1'b1;
   assign rd_en     = (state_reg == RD_DATA) && rd_more_reg && (!rvalid_reg || S_AXI_RREADY);

   assign unused_addr = ^{S_AXI_AWADDR[ADDR_W-1:DEPTH_LOG2+4], S_AXI_AWADDR[3:0],
                          S_AXI_ARADDR[ADDR_W-1:DEPTH_LOG2+4], S_AXI_ARADDR[3:0]};

   assign S_AXI_AWREADY = aw_sel;
   assign S_AXI_ARREADY = ar_sel;
   assign S_AXI_WREADY  = wready_reg;
   assign S_AXI_BVALID  = bvalid_reg;
   assign S_AXI_BRESP   = bresp_reg;
   assign S_AXI_RVALID  = rvalid_reg;
   assign S_AXI_RLAST   = rlast_reg;
   assign S_AXI_RRESP   = OKAY;

   axi_mem_array #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .we    (w_hs),
      .waddr (line_reg),
      .wdata (S_AXI_WDATA),
      .wstrb (S_AXI_WSTRB),
      .re    (rd_en),
      .raddr (line_reg),
      .rdata (S_AXI_RDATA)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         prio_wr_reg <= 1'b1;
         line_reg    <= '0;
         len_reg     <= '0;
         cnt_reg     <= '0;
         fixed_reg   <= 1'b0;
         err_reg     <= 1'b0;
         rd_more_reg <= 1'b0;
         wready_reg  <= 1'b0;
         bvalid_reg  <= 1'b0;
         bresp_reg   <= OKAY;
         rvalid_reg  <= 1'b0;
         rlast_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (aw_sel) begin
                  line_reg    <= S_AXI_AWADDR[DEPTH_LOG2+3:4];
                  len_reg     <= S_AXI_AWLEN;
                  fixed_reg   <= is_fixed(S_AXI_AWBURST);
                  cnt_reg     <= '0;
                  err_reg     <= 1'b0;
                  wready_reg  <= 1'b1;
                  prio_wr_reg <= ~prio_wr_reg;
                  state_reg   <= WR_DATA;
               end else if (ar_sel) begin
                  line_reg    <= S_AXI_ARADDR[DEPTH_LOG2+3:4];
                  len_reg     <= S_AXI_ARLEN;
                  fixed_reg   <= is_fixed(S_AXI_ARBURST);
                  cnt_reg     <= '0;
                  rd_more_reg <= 1'b1;
                  prio_wr_reg <= ~prio_wr_reg;
                  state_reg   <= RD_DATA;
               end
            end
            WR_DATA: begin
               // Burst length comes from LEN; WLAST only feeds the error response.
               if (w_hs) begin
                  if (last_beat) begin
                     wready_reg <= 1'b0;
                     bvalid_reg <= 1'b1;
                     bresp_reg  <= (err_reg || !S_AXI_WLAST) ? SLVERR : OKAY;
                     state_reg  <= WR_RESP;
                  end else begin
                     cnt_reg  <= cnt_reg + 8'd1;
                     line_reg <= line_next;
                     if (S_AXI_WLAST) begin
                        err_reg <= 1'b1;
                     end
                  end
               end
            end
            WR_RESP: begin
               if (S_AXI_BREADY) begin
                  bvalid_reg <= 1'b0;
                  bresp_reg  <= OKAY;
                  state_reg  <= IDLE;
               end
            end
            RD_DATA: begin
               if (rd_en) begin
                  rvalid_reg <= 1'b1;
                  rlast_reg  <= last_beat;
                  line_reg   <= line_next;
                  if (last_beat) begin
                     rd_more_reg <= 1'b0;
                  end else begin
                     cnt_reg <= cnt_reg + 8'd1;
                  end
               end else if (rvalid_reg && S_AXI_RREADY) begin
                  rvalid_reg <= 1'b0;
                  rlast_reg  <= 1'b0;
                  if (rlast_reg) begin
                     state_reg <= IDLE;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: bursts, strobes, stalls, arbitration, WLAST errors, mid-burst reset.
module tb_axi_mem_slave;

   logic          clk = 1'b0;
   logic          rst;
   logic [26:0]   S_AXI_AWADDR;
   logic [7:0]    S_AXI_AWLEN;
   logic [1:0]    S_AXI_AWBURST;
   logic          S_AXI_AWVALID;
   logic          S_AXI_AWREADY;
   logic [127:0]  S_AXI_WDATA;
   logic [15:0]   S_AXI_WSTRB;
   logic          S_AXI_WLAST;
   logic          S_AXI_WVALID;
   logic          S_AXI_WREADY;
   logic [1:0]    S_AXI_BRESP;
   logic          S_AXI_BVALID;
   logic          S_AXI_BREADY;
   logic [26:0]   S_AXI_ARADDR;
   logic [7:0]    S_AXI_ARLEN;
   logic [1:0]    S_AXI_ARBURST;
   logic          S_AXI_ARVALID;
   logic          S_AXI_ARREADY;
   logic [127:0]  S_AXI_RDATA;
   logic [1:0]    S_AXI_RRESP;
   logic          S_AXI_RLAST;
   logic          S_AXI_RVALID;
   logic          S_AXI_RREADY;

   always #5 clk = ~clk;

   axi_mem_slave dut (
      .clk           (clk),
      .rst           (rst),
      .S_AXI_AWADDR  (S_AXI_AWADDR),
      .S_AXI_AWLEN   (S_AXI_AWLEN),
      .S_AXI_AWBURST (S_AXI_AWBURST),
      .S_AXI_AWVALID (S_AXI_AWVALID),
      .S_AXI_AWREADY (S_AXI_AWREADY),
      .S_AXI_WDATA   (S_AXI_WDATA),
      .S_AXI_WSTRB   (S_AXI_WSTRB),
      .S_AXI_WLAST   (S_AXI_WLAST),
      .S_AXI_WVALID  (S_AXI_WVALID),
      .S_AXI_WREADY  (S_AXI_WREADY),
      .S_AXI_BRESP   (S_AXI_BRESP),
      .S_AXI_BVALID  (S_AXI_BVALID),
      .S_AXI_BREADY  (S_AXI_BREADY),
      .S_AXI_ARADDR  (S_AXI_ARADDR),
      .S_AXI_ARLEN   (S_AXI_ARLEN),
      .S_AXI_ARBURST (S_AXI_ARBURST),
      .S_AXI_ARVALID (S_AXI_ARVALID),
      .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_RDATA   (S_AXI_RDATA),
      .S_AXI_RRESP   (S_AXI_RRESP),
      .S_AXI_RLAST   (S_AXI_RLAST),
      .S_AXI_RVALID  (S_AXI_RVALID),
      .S_AXI_RREADY  (S_AXI_RREADY)
   );

   int           n_checks = 0;
   int           n_fail   = 0;
   int           stall_bad;
   int           lat;
   int           beat;
   logic [1:0]   bresp;
   logic [127:0] wdat [0:7];
   logic [15:0]  wstr [0:7];
   logic [127:0] rd_data [0:7];
   logic         rd_last [0:7];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_aw();
      int n = 0;
      #1;
      while (!S_AXI_AWREADY && n < 50) begin @(negedge clk); #1; n++; end
      check("aw_handshake", 128'(S_AXI_AWREADY), 128'd1);
   endtask

   task automatic wait_ar();
      int n = 0;
      #1;
      while (!S_AXI_ARREADY && n < 50) begin @(negedge clk); #1; n++; end
      check("ar_handshake", 128'(S_AXI_ARREADY), 128'd1);
   endtask

   task automatic wait_w();
      int n = 0;
      #1;
      while (!S_AXI_WREADY && n < 50) begin @(negedge clk); #1; n++; end
      check("w_handshake", 128'(S_AXI_WREADY), 128'd1);
   endtask

   task automatic wait_b();
      int n = 0;
      #1;
      while (!S_AXI_BVALID && n < 50) begin @(negedge clk); #1; n++; end
      check("b_handshake", 128'(S_AXI_BVALID), 128'd1);
   endtask

   // Call in the low clock phase; returns in the low phase after the B handshake.
   task automatic axi_write(input logic [26:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input int bad_beat, output logic [1:0] resp);
      S_AXI_AWADDR  = addr;
      S_AXI_AWLEN   = len;
      S_AXI_AWBURST = burst;
      S_AXI_AWVALID = 1'b1;
      wait_aw();
      @(posedge clk); @(negedge clk);
      S_AXI_AWVALID = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         S_AXI_WDATA  = wdat[i];
         S_AXI_WSTRB  = wstr[i];
         S_AXI_WLAST  = (i == int'(len)) || (i == bad_beat);
         S_AXI_WVALID = 1'b1;
         wait_w();
         @(posedge clk); @(negedge clk);
      end
      S_AXI_WVALID = 1'b0;
      S_AXI_WLAST  = 1'b0;
      S_AXI_BREADY = 1'b1;
      wait_b();
      resp = S_AXI_BRESP;
      @(posedge clk); @(negedge clk);
      S_AXI_BREADY = 1'b0;
      $display("write addr=%h len=%0d burst=%0d bresp=%0d", addr, len, burst, resp);
   endtask

   // first_lat counts clock edges after the AR handshake edge until RVALID is first seen.
   task automatic axi_read(input logic [26:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [3:0] rpat, output int first_lat);
      int           cyc = 0;
      int           got = 0;
      logic         held_v = 1'b0;
      logic [127:0] held_d = '0;
      logic         held_l = 1'b0;
      S_AXI_ARADDR  = addr;
      S_AXI_ARLEN   = len;
      S_AXI_ARBURST = burst;
      S_AXI_ARVALID = 1'b1;
      wait_ar();
      @(posedge clk); @(negedge clk);
      S_AXI_ARVALID = 1'b0;
      first_lat = -1;
      stall_bad = 0;
      while (got <= int'(len) && cyc < 100) begin
         S_AXI_RREADY = rpat[cyc % 4];
         #1;
         if (S_AXI_RVALID && first_lat < 0) first_lat = cyc;
         if (held_v && (!S_AXI_RVALID || S_AXI_RDATA !== held_d || S_AXI_RLAST !== held_l)) stall_bad++;
         held_v = 1'b0;
         if (S_AXI_RVALID) begin
            if (S_AXI_RREADY) begin
               if (got < 8) begin
                  rd_data[got] = S_AXI_RDATA;
                  rd_last[got] = S_AXI_RLAST;
               end
               got++;
            end else begin
               held_v = 1'b1;
               held_d = S_AXI_RDATA;
               held_l = S_AXI_RLAST;
            end
         end
         @(posedge clk); @(negedge clk);
         cyc++;
      end
      S_AXI_RREADY = 1'b0;
      check("r_beat_count", 128'(got), 128'(int'(len) + 1));
      $display("read  addr=%h len=%0d burst=%0d beats=%0d first_lat=%0d", addr, len, burst, got, first_lat);
   endtask

   initial begin
      rst = 1'b0;
      S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWBURST = 2'b01; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
      S_AXI_BREADY = 1'b0;
      S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARBURST = 2'b01; S_AXI_ARVALID = 1'b1;
      S_AXI_RREADY = 1'b0;
      for (int i = 0; i < 8; i++) begin wdat[i] = '0; wstr[i] = 16'hFFFF; end

      // Reset state, with both address VALIDs held high
      repeat (3) @(negedge clk);
      #1;
      check("rst_awready", 128'(S_AXI_AWREADY), 128'd0);
      check("rst_arready", 128'(S_AXI_ARREADY), 128'd0);
      check("rst_wready",  128'(S_AXI_WREADY),  128'd0);
      check("rst_bvalid",  128'(S_AXI_BVALID),  128'd0);
      check("rst_rvalid",  128'(S_AXI_RVALID),  128'd0);
      check("rst_rlast",   128'(S_AXI_RLAST),   128'd0);
      check("rst_bresp",   128'(S_AXI_BRESP),   128'd0);
      check("rst_rresp",   128'(S_AXI_RRESP),   128'd0);
      check("rst_rdata",   S_AXI_RDATA,         128'd0);
      $display("reset checked");

      // Simultaneous AW/AR out of reset: write wins, read waits until after B
      @(negedge clk);
      rst = 1'b1;
      S_AXI_AWADDR = 27'h0000100; S_AXI_AWLEN = 8'd0;
      S_AXI_ARADDR = 27'h0000100; S_AXI_ARLEN = 8'd0;
      #1;
      check("arb_awready", 128'(S_AXI_AWREADY), 128'd1);
      check("arb_arready", 128'(S_AXI_ARREADY), 128'd0);
      @(posedge clk); @(negedge clk);
      S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA = 128'h0123456789ABCDEF0123456789ABCDEF;
      S_AXI_WSTRB = 16'hFFFF; S_AXI_WLAST = 1'b1; S_AXI_WVALID = 1'b1;
      #1;
      check("arb_ar_blocked_wdata", 128'(S_AXI_ARREADY), 128'd0);
      check("arb_wready", 128'(S_AXI_WREADY), 128'd1);
      @(posedge clk); @(negedge clk);
      S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
      #1;
      check("arb_bvalid", 128'(S_AXI_BVALID), 128'd1);
      check("arb_bresp", 128'(S_AXI_BRESP), 128'd0);
      check("arb_wready_dropped", 128'(S_AXI_WREADY), 128'd0);
      check("arb_ar_blocked_bresp", 128'(S_AXI_ARREADY), 128'd0);
      S_AXI_BREADY = 1'b1;
      @(posedge clk); @(negedge clk);
      S_AXI_BREADY = 1'b0;
      #1;
      check("arb_bvalid_cleared", 128'(S_AXI_BVALID), 128'd0);
      $display("arbitration write done, read pending");
      axi_read(27'h0000100, 8'd0, 2'b01, 4'b1111, lat);
      check("single_rdata", rd_data[0], 128'h0123456789ABCDEF0123456789ABCDEF);
      check("single_rlast", 128'(rd_last[0]), 128'd1);
      check("single_latency", 128'(lat), 128'd1);

      // INCR burst wrapping from line 4095 to lines 0..2, read back with RREADY stalls
      wdat[0] = {4{32'h11111111}}; wdat[1] = {4{32'h22222222}};
      wdat[2] = {4{32'h33333333}}; wdat[3] = {4{32'h44444444}};
      axi_write(27'h07FFFF0, 8'd3, 2'b01, -1, bresp);
      check("incr_bresp", 128'(bresp), 128'd0);
      axi_read(27'h07FFFF0, 8'd3, 2'b01, 4'b1001, lat);
      check("incr_beat0", rd_data[0], {4{32'h11111111}});
      check("incr_beat1", rd_data[1], {4{32'h22222222}});
      check("incr_beat2", rd_data[2], {4{32'h33333333}});
      check("incr_beat3", rd_data[3], {4{32'h44444444}});
      check("incr_rlast", 128'({rd_last[0], rd_last[1], rd_last[2], rd_last[3]}), 128'b0001);
      check("incr_stall_stable", 128'(stall_bad), 128'd0);
      axi_read(27'h0000000, 8'd0, 2'b01, 4'b1111, lat);
      check("wrap_line0", rd_data[0], {4{32'h22222222}});
      axi_read(27'h0010010, 8'd0, 2'b11, 4'b1111, lat);
      check("alias_line1", rd_data[0], {4{32'h33333333}});

      // Byte strobes: clear only the low 8 bytes
      wdat[0] = '1; wstr[0] = 16'hFFFF;
      axi_write(27'h0000200, 8'd0, 2'b01, -1, bresp);
      wdat[0] = '0; wstr[0] = 16'h00FF;
      axi_write(27'h0000200, 8'd0, 2'b01, -1, bresp);
      wstr[0] = 16'hFFFF;
      axi_read(27'h0000200, 8'd0, 2'b01, 4'b1111, lat);
      check("wstrb_merge", rd_data[0], 128'hFFFFFFFFFFFFFFFF0000000000000000);

      // FIXED bursts hold the line
      wdat[0] = {4{32'hCCCCCCCC}};
      axi_write(27'h0000310, 8'd0, 2'b01, -1, bresp);
      wdat[0] = {4{32'hAAAAAAAA}}; wdat[1] = {4{32'hBBBBBBBB}};
      axi_write(27'h0000300, 8'd1, 2'b00, -1, bresp);
      check("fixed_bresp", 128'(bresp), 128'd0);
      axi_read(27'h0000300, 8'd1, 2'b01, 4'b1111, lat);
      check("fixed_wr_line30", rd_data[0], {4{32'hBBBBBBBB}});
      check("fixed_wr_line31", rd_data[1], {4{32'hCCCCCCCC}});
      axi_read(27'h0000300, 8'd1, 2'b00, 4'b1111, lat);
      check("fixed_rd_beat1", rd_data[1], {4{32'hBBBBBBBB}});
      check("fixed_rd_rlast", 128'({rd_last[0], rd_last[1]}), 128'b01);

      // Early WLAST: both beats still taken, SLVERR returned
      wdat[0] = {4{32'h55555555}}; wdat[1] = {4{32'h66666666}};
      axi_write(27'h0000500, 8'd1, 2'b01, 0, bresp);
      check("early_wlast_bresp", 128'(bresp), 128'd2);
      axi_read(27'h0000500, 8'd1, 2'b01, 4'b1111, lat);
      check("early_wlast_beat0", rd_data[0], {4{32'h55555555}});
      check("early_wlast_beat1", rd_data[1], {4{32'h66666666}});

      // Reset during beat 2 of an 8-beat read
      for (int i = 0; i < 8; i++) wdat[i] = {16{8'(8'h80 + i)}};
      axi_write(27'h0000400, 8'd7, 2'b01, -1, bresp);
      check("len7_bresp", 128'(bresp), 128'd0);
      S_AXI_ARADDR = 27'h0000400; S_AXI_ARLEN = 8'd7; S_AXI_ARBURST = 2'b01; S_AXI_ARVALID = 1'b1;
      wait_ar();
      @(posedge clk); @(negedge clk);
      S_AXI_RREADY = 1'b1;
      beat = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (S_AXI_RVALID && beat == 2) break;
         if (S_AXI_RVALID) beat++;
         @(posedge clk); @(negedge clk);
      end
      check("midrst_beat2_data", S_AXI_RDATA, {16{8'h82}});
      rst = 1'b0;
      #1;
      check("midrst_rvalid", 128'(S_AXI_RVALID), 128'd0);
      check("midrst_rlast",  128'(S_AXI_RLAST),  128'd0);
      check("midrst_arready", 128'(S_AXI_ARREADY), 128'd0);
      check("midrst_wready", 128'(S_AXI_WREADY), 128'd0);
      check("midrst_bvalid", 128'(S_AXI_BVALID), 128'd0);
      $display("mid-burst reset applied");
      S_AXI_RREADY = 1'b0; S_AXI_ARVALID = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      axi_read(27'h0000400, 8'd0, 2'b01, 4'b1111, lat);
      check("post_rst_rdata", rd_data[0], {16{8'h80}});
      check("post_rst_rlast", 128'(rd_last[0]), 128'd1);
      check("post_rst_latency", 128'(lat), 128'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
